// File: rtl/operand_sender_pkg.sv
// Shared definitions for the operand/result stable-ack protocol (sender and controller sides).
// Contents: transaction state encoding, default widths, opcode constants, watchdog-activity helper.
// No logic of its own; imported by operand_sender and its sub-module users.
package operand_sender_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_OP_W   = 3;

  localparam logic [DEF_OP_W-1:0] OP_ADD = 3'b000;

  typedef enum logic [3:0] {
    IDLE,
    SEND_A,
    REL_A,
    SEND_B,
    REL_B,
    SEND_OP,
    REL_OP,
    WAIT_Z,
    REL_Z,
    RESP
  } state_t;

  // The watchdog only guards states that wait on the controller.
  function automatic logic wd_active(input state_t s);
    return (s != IDLE) && (s != RESP);
  endfunction

endpackage

// File: rtl/operand_sender_handshake_watchdog.sv
// Clearable saturating cycle counter; flags when TIMEOUT-1 cycles have elapsed in one wait.
// Ports: clk/rst, enable (counting allowed), clear (restart from 0), expired (combinational flag).
// Latency: expired is high during the TIMEOUT-th consecutive enabled cycle without a clear.
module handshake_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/operand_sender.sv
// Initiator of the operand/result stable-ack protocol: takes {a,b,op}, sends each with a
// four-phase handshake, collects z, and returns {z,err} on a valid/ready response port.
// Ports: req_* (upstream request), output_*/input_*_ack (operands), input_z*/output_z_ack (result),
// resp_* (upstream response). Min latency: resp_valid in the 9th cycle after the accepting edge.
module operand_sender
  import operand_sender_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  output logic [DATA_W-1:0] output_a,
  output logic              output_a_stable,
  input  logic              input_a_ack,
  output logic [DATA_W-1:0] output_b,
  output logic              output_b_stable,
  input  logic              input_b_ack,
  output logic [OP_W-1:0]   output_op,
  output logic              output_op_stable,
  input  logic              input_op_ack,
  input  logic [DATA_W-1:0] input_z,
  input  logic              input_z_stable,
  output logic              output_z_ack,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_z,
  output logic              resp_err
);

  state_t state;
  logic   exit_cond;
  logic   wd_expired;

  // Condition that ends the current wait state; also restarts the watchdog.
  always_comb begin
    exit_cond = 1'b0;
    case (state)
      SEND_A:  exit_cond = input_a_ack;
      REL_A:   exit_cond = !input_a_ack;
      SEND_B:  exit_cond = input_b_ack;
      REL_B:   exit_cond = !input_b_ack;
      SEND_OP: exit_cond = input_op_ack;
      REL_OP:  exit_cond = !input_op_ack;
      WAIT_Z:  exit_cond = input_z_stable;
      REL_Z:   exit_cond = !input_z_stable;
      default: exit_cond = 1'b0;
    endcase
  end

  handshake_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enable (wd_active(state)),
    .clear  (exit_cond),
    .expired(wd_expired)
  );

  // output_a/b/op double as the capture registers, so they only change on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      req_ready        <= 1'b0;
      output_a         <= '0;
      output_b         <= '0;
      output_op        <= '0;
      output_a_stable  <= 1'b0;
      output_b_stable  <= 1'b0;
      output_op_stable <= 1'b0;
      output_z_ack     <= 1'b0;
      resp_valid       <= 1'b0;
      resp_z           <= '0;
      resp_err         <= 1'b0;
    end else if (wd_expired && !exit_cond) begin
      // Abort: an exit arriving on the timeout cycle takes priority (handled below).
      output_a_stable  <= 1'b0;
      output_b_stable  <= 1'b0;
      output_op_stable <= 1'b0;
      output_z_ack     <= 1'b0;
      resp_valid       <= 1'b1;
      resp_z           <= '0;
      resp_err         <= 1'b1;
      state            <= RESP;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready       <= 1'b0;
            output_a        <= req_a;
            output_b        <= req_b;
            output_op       <= req_op;
            output_a_stable <= 1'b1;
            state           <= SEND_A;
          end
        end
        SEND_A: if (input_a_ack) begin
          output_a_stable <= 1'b0;
          state           <= REL_A;
        end
        REL_A: if (!input_a_ack) begin
          output_b_stable <= 1'b1;
          state           <= SEND_B;
        end
        SEND_B: if (input_b_ack) begin
          output_b_stable <= 1'b0;
          state           <= REL_B;
        end
        REL_B: if (!input_b_ack) begin
          output_op_stable <= 1'b1;
          state            <= SEND_OP;
        end
        SEND_OP: if (input_op_ack) begin
          output_op_stable <= 1'b0;
          state            <= REL_OP;
        end
        REL_OP: if (!input_op_ack) begin
          state <= WAIT_Z;
        end
        WAIT_Z: if (input_z_stable) begin
          resp_z       <= input_z;
          output_z_ack <= 1'b1;
          state        <= REL_Z;
        end
        REL_Z: if (!input_z_stable) begin
          output_z_ack <= 1'b0;
          resp_valid   <= 1'b1;
          resp_err     <= 1'b0;
          state        <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sender.sv
// Bench for operand_sender: a configurable controller peer answers the handshakes, and each
// transaction's latency, per-channel stable durations, result and error flag are compared
// against values derived from the protocol rules (dwell per wait state, watchdog limit).
`timescale 1ns/1ps
module tb_operand_sender;

  localparam int DW = 64;
  localparam int OW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic [OW-1:0] req_op = '0;
  logic [DW-1:0] output_a, output_b;
  logic [OW-1:0] output_op;
  logic          output_a_stable, output_b_stable, output_op_stable;
  logic          input_a_ack, input_b_ack, input_op_ack;
  logic [DW-1:0] input_z = '0;
  logic          input_z_stable = 1'b0;
  logic          output_z_ack;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_z;
  logic          resp_err;

  always #5 clk = ~clk;

  operand_sender #(.DATA_W(DW), .OP_W(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .output_a(output_a), .output_a_stable(output_a_stable), .input_a_ack(input_a_ack),
    .output_b(output_b), .output_b_stable(output_b_stable), .input_b_ack(input_b_ack),
    .output_op(output_op), .output_op_stable(output_op_stable), .input_op_ack(input_op_ack),
    .input_z(input_z), .input_z_stable(input_z_stable), .output_z_ack(output_z_ack),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_z(resp_z), .resp_err(resp_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Result the peer computes; every opcode value gives a distinct function.
  function automatic logic [63:0] zfn(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return a ^ b ^ {61'd0, op};
    endcase
  endfunction

  // ---------------- controller peer ----------------
  int   ack_dly[3] = '{0, 0, 0};
  int   rel_dly[3] = '{0, 0, 0};
  bit   never_ack[3] = '{0, 0, 0};
  bit   z_hold = 1'b0;
  logic [2:0] ack_r = '0;
  int   pcnt[3] = '{0, 0, 0};
  logic [63:0] pa = '0, pb = '0;
  logic [2:0]  pop = '0;
  bit   z_pend = 1'b0;
  logic [2:0] stab;

  assign stab = {output_op_stable, output_b_stable, output_a_stable};
  assign input_a_ack  = ack_r[0];
  assign input_b_ack  = ack_r[1];
  assign input_op_ack = ack_r[2];

  always @(posedge clk) begin
    #1;
    if (rst) begin
      ack_r = '0;
      z_pend = 1'b0;
      input_z_stable = 1'b0;
      input_z = '0;
      for (int i = 0; i < 3; i++) pcnt[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stab[i] && !ack_r[i]) begin
          if (!never_ack[i]) begin
            if (pcnt[i] >= ack_dly[i]) begin
              ack_r[i] = 1'b1;
              pcnt[i] = 0;
              if (i == 0) pa = output_a;
              else if (i == 1) pb = output_b;
              else begin pop = output_op; z_pend = 1'b1; end
            end else pcnt[i]++;
          end
        end else if (!stab[i] && ack_r[i]) begin
          if (pcnt[i] >= rel_dly[i]) begin ack_r[i] = 1'b0; pcnt[i] = 0; end
          else pcnt[i]++;
        end else pcnt[i] = 0;
      end
      if (output_z_ack) begin
        if (!z_hold) begin input_z_stable = 1'b0; z_pend = 1'b0; end
      end else if (z_pend) begin
        input_z_stable = 1'b1;
        input_z = zfn(pa, pb, pop);
      end
    end
  end

  // ---------------- monitor ----------------
  logic [63:0] cur_a = '0, cur_b = '0;
  logic [2:0]  cur_op = '0;
  int txn_seq = 0, last_seq = 0;
  int hi_cnt[3] = '{0, 0, 0};
  int bad_data = 0, bad_proto = 0;

  always @(negedge clk) begin
    if (txn_seq != last_seq) begin
      last_seq = txn_seq;
      for (int i = 0; i < 3; i++) hi_cnt[i] = 0;
      bad_data = 0;
      bad_proto = 0;
    end
    if (!rst) begin
      if (output_a_stable) begin hi_cnt[0]++; if (output_a !== cur_a) bad_data++; end
      if (output_b_stable) begin hi_cnt[1]++; if (output_b !== cur_b) bad_data++; end
      if (output_op_stable) begin hi_cnt[2]++; if (output_op !== cur_op) bad_data++; end
      if ((output_b_stable && input_a_ack) || (output_op_stable && input_b_ack) ||
          (output_z_ack && input_op_ack)) bad_proto++;
      if ($countones({output_a_stable, output_b_stable, output_op_stable, output_z_ack}) > 1)
        bad_proto++;
    end
  end

  task automatic set_peer(input int ad, input int ar, input int bd, input int br,
                          input int od, input int orl, input bit never_op);
    ack_dly[0] = ad; rel_dly[0] = ar;
    ack_dly[1] = bd; rel_dly[1] = br;
    ack_dly[2] = od; rel_dly[2] = orl;
    never_ack[0] = 1'b0; never_ack[1] = 1'b0; never_ack[2] = never_op;
  endtask

  task automatic do_txn(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op, input int bp);
    int dw[6];
    int exp_hi[3];
    int lat, n, cyc;
    bit err;
    logic [63:0] exp_z;
    // Reference: each SEND lasts ack delay + 1 cycles, each REL release delay + 1,
    // WAIT_Z and REL_Z one each; a wait longer than TO is cut at TO and aborts.
    for (int c = 0; c < 3; c++) begin
      dw[2*c]   = never_ack[c] ? 1000000 : ack_dly[c] + 1;
      dw[2*c+1] = rel_dly[c] + 1;
      exp_hi[c] = 0;
    end
    lat = 0;
    err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) exp_hi[i/2] = (dw[i] > TO) ? TO : dw[i];
      if (dw[i] > TO) begin lat += TO; err = 1'b1; break; end
      lat += dw[i];
    end
    if (!err) lat += 2;
    exp_z = err ? 64'd0 : zfn(a, b, op);

    n = 0;
    while (!req_ready && n < 64) begin @(negedge clk); n++; end
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    cur_a = a; cur_b = b; cur_op = op;
    txn_seq++;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_op = 3'($urandom);
    cyc = 1;
    while (!resp_valid && cyc < 400) begin @(negedge clk); cyc++; end
    chk("resp_latency", 64'(cyc), 64'(lat + 1));
    chk("resp_z", resp_z, exp_z);
    chk("resp_err", 64'(resp_err), 64'(err));
    chk("a_stable_cycles", 64'(hi_cnt[0]), 64'(exp_hi[0]));
    chk("b_stable_cycles", 64'(hi_cnt[1]), 64'(exp_hi[1]));
    chk("op_stable_cycles", 64'(hi_cnt[2]), 64'(exp_hi[2]));
    chk("operand_data_held", 64'(bad_data), 64'd0);
    chk("handshake_order", 64'(bad_proto), 64'd0);
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1;
      req_a = {$urandom, $urandom};
      @(negedge clk);
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_z", resp_z, exp_z);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_no_accept", 64'(output_a_stable), 64'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_cleared", 64'(resp_valid), 64'd0);
    chk("req_ready_after_resp", 64'(req_ready), 64'd1);
  endtask

  initial begin
    int n;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_stables", 64'({output_a_stable, output_b_stable, output_op_stable}), 64'd0);
    chk("rst_z_ack", 64'(output_z_ack), 64'd0);
    chk("rst_resp", 64'({resp_valid, resp_err}), 64'd0);
    chk("rst_data", output_a | output_b | resp_z | 64'(output_op), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_post_rst", 64'(req_ready), 64'd1);

    // Nominal, same-cycle peer.
    set_peer(0, 0, 0, 0, 0, 0, 1'b0);
    do_txn(64'h5, 64'h7, 3'd0, 0);
    // Slow b peer plus response backpressure.
    set_peer(0, 0, 5, 3, 0, 0, 1'b0);
    do_txn(64'h5, 64'h7, 3'd0, 4);
    // Opcode never acknowledged: watchdog abort, then a clean transaction.
    set_peer(0, 0, 0, 0, 0, 0, 1'b1);
    do_txn(64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 3'd5, 1);
    set_peer(0, 0, 0, 0, 0, 0, 1'b0);
    do_txn(64'hdead_beef_0000_0001, 64'h1, 3'd1, 0);
    // Exit on the last permitted cycle wins; one more cycle aborts.
    set_peer(0, 0, 15, 0, 0, 0, 1'b0);
    do_txn(64'h11, 64'h22, 3'd3, 0);
    set_peer(0, 15, 0, 0, 0, 0, 1'b0);
    do_txn(64'h33, 64'h44, 3'd2, 0);
    set_peer(16, 0, 0, 0, 0, 0, 1'b0);
    do_txn(64'h55, 64'h66, 3'd4, 2);

    for (int t = 0; t < 24; t++) begin
      set_peer($urandom_range(0, 16), $urandom_range(0, 6), $urandom_range(0, 16),
               $urandom_range(0, 6), $urandom_range(0, 16), $urandom_range(0, 6),
               ($urandom_range(0, 7) == 0));
      do_txn({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
             $urandom_range(0, 3));
    end

    // Asynchronous reset while the result acknowledge is held.
    set_peer(0, 0, 0, 0, 0, 0, 1'b0);
    z_hold = 1'b1;
    txn_seq++;
    req_a = 64'h77; req_b = 64'h88; req_op = 3'd6; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!output_z_ack && n < 64) begin @(negedge clk); n++; end
    chk("reached_rel_z", 64'(output_z_ack), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_z_ack", 64'(output_z_ack), 64'd0);
    chk("async_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("async_rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    z_hold = 1'b0;
    @(negedge clk);
    chk("req_ready_after_async_rst", 64'(req_ready), 64'd1);
    do_txn(64'h5, 64'h7, 3'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
